// File: rtl/mem_rd_arb3x.sv
// Round-robin arbiter sharing one memory read port among G_NREQ requesters, routing data back by tag.
// Latency: grant to response is G_LAT+2 cycles; no response backpressure, clrrdy=0 stalls new grants.
module mem_rd_arb3x #(
    parameter int G_NREQ    = 4,
    parameter int G_RDADDR  = 10,
    parameter int G_RDWIDTH = 16,
    parameter int G_LAT     = 3
) (
    input  logic                         rclk,
    input  logic                         rst_n,
    input  logic                         clrrdy,
    input  logic [G_NREQ-1:0]            req_vld,
    input  logic [G_NREQ*G_RDADDR-1:0]   req_add,
    output logic [G_NREQ-1:0]            req_rdy,
    output logic                         memre,
    output logic [G_RDADDR-1:0]          memra,
    input  logic [G_RDWIDTH-1:0]         memdo,
    output logic [G_NREQ-1:0]            rsp_vld,
    output logic [G_RDWIDTH-1:0]         rsp_dat,
    output logic                         busy
);

    localparam int PW = $clog2(G_NREQ);

    logic [PW-1:0]                  ptr;
    logic [PW-1:0]                  gidx;
    logic                           gany;
    logic [G_NREQ-1:0]              grant;
    logic [G_RDADDR-1:0]            sel_add;
    logic [G_LAT:0][G_NREQ-1:0]     tag;
    int                             idx;

    // Search upward from ptr; the first requester found wins.
    always_comb begin
        gidx = '0;
        gany = 1'b0;
        idx  = 0;
        if (clrrdy) begin
            for (int k = 0; k < G_NREQ; k++) begin
                idx = (int'(ptr) + k) % G_NREQ;
                if (!gany && req_vld[idx]) begin
                    gany = 1'b1;
                    gidx = PW'(idx);
                end
            end
        end
        grant   = gany ? (G_NREQ'(1) << gidx) : '0;
        sel_add = req_add[int'(gidx)*G_RDADDR +: G_RDADDR];
    end

    assign req_rdy = grant;

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            ptr   <= '0;
            memre <= 1'b0;
            memra <= '0;
        end else begin
            memre <= gany;
            if (gany) begin
                memra <= sel_add;
                ptr   <= (gidx == PW'(G_NREQ - 1)) ? '0 : gidx + PW'(1);
            end
        end
    end

    // Tag stage 0 lines up with memre; stage G_LAT lines up with valid memdo.
    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            tag     <= '0;
            rsp_vld <= '0;
            rsp_dat <= '0;
            busy    <= 1'b0;
        end else begin
            tag     <= {tag[G_LAT-1:0], grant};
            rsp_vld <= tag[G_LAT];
            if (|tag[G_LAT]) begin
                rsp_dat <= memdo;
            end
            busy    <= gany | (|tag[G_LAT-1:0]);
        end
    end

endmodule

// File: tb/tb_mem_rd_arb3x.sv
// Directed + random bench for mem_rd_arb3x with a 3-cycle memory model and response scoreboard.
module tb_mem_rd_arb3x;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic              rclk;
    logic              rst_n;
    logic              clrrdy;
    logic [N-1:0]      req_vld;
    logic [N*AW-1:0]   req_add;
    logic [N-1:0]      req_rdy;
    logic              memre;
    logic [AW-1:0]     memra;
    logic [DW-1:0]     memdo;
    logic [N-1:0]      rsp_vld;
    logic [DW-1:0]     rsp_dat;
    logic              busy;

    mem_rd_arb3x #(.G_NREQ(N), .G_RDADDR(AW), .G_RDWIDTH(DW), .G_LAT(LAT)) dut (
        .rclk    (rclk),
        .rst_n   (rst_n),
        .clrrdy  (clrrdy),
        .req_vld (req_vld),
        .req_add (req_add),
        .req_rdy (req_rdy),
        .memre   (memre),
        .memra   (memra),
        .memdo   (memdo),
        .rsp_vld (rsp_vld),
        .rsp_dat (rsp_dat),
        .busy    (busy)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int           due;
        logic [N-1:0] vld;
        logic [DW-1:0] dat;
    } exp_t;
    exp_t q[$];

    int            mptr;
    logic          exp_memre;
    logic [AW-1:0] exp_memra;
    logic [DW-1:0] exp_dat;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {a[5:0], a} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: data for the address presented with memre appears LAT cycles later; garbage otherwise.
    logic [DW-1:0] p1, p2;
    always @(posedge rclk) begin
        p1    <= memre ? mdata(memra) : DW'($urandom);
        p2    <= p1;
        memdo <= p2;
    end

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge rclk) begin
        logic [N-1:0] eg;
        int           gi;
        int           j;
        cyc++;
        if (chk_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rsp_vld", 32'(rsp_vld), 32'(q[0].vld));
                chk("rsp_dat", 32'(rsp_dat), 32'(q[0].dat));
                exp_dat = q[0].dat;
                void'(q.pop_front());
            end else begin
                chk("rsp_vld_idle", 32'(rsp_vld), 32'(0));
                chk("rsp_dat_hold", 32'(rsp_dat), 32'(exp_dat));
            end
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("memre", 32'(memre), 32'(exp_memre));
            chk("memra", 32'(memra), 32'(exp_memra));

            eg = '0;
            gi = -1;
            if (clrrdy) begin
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (gi < 0 && req_vld[j]) gi = j;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk("req_rdy", 32'(req_rdy), 32'(eg));

            exp_memre = (gi >= 0);
            if (gi >= 0) begin
                exp_memra = req_add[gi*AW +: AW];
                q.push_back('{due: cyc + LAT + 2, vld: eg, dat: mdata(exp_memra)});
                mptr = (gi + 1) % N;
            end
        end
        if (!rst_n) begin
            q.delete();
            mptr      = 0;
            exp_memre = 1'b0;
            exp_memra = '0;
            exp_dat   = '0;
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic c, input int n);
        req_vld = v;
        clrrdy  = c;
        repeat (n) @(posedge rclk);
        #1;
    endtask

    logic [AW-1:0] hold_add;

    initial begin
        rst_n   = 1'b0;
        clrrdy  = 1'b0;
        req_vld = '0;
        req_add = {10'h3C4, 10'h2AB, 10'h155, 10'h0F0};
        repeat (3) @(posedge rclk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_memre", 32'(memre), 32'(0));
        chk("rst_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        drive('0, 1'b1, 2);

        // Single request from requester 1.
        req_vld = 4'b0010;
        #1 chk("t1_rdy", 32'(req_rdy), 32'(4'b0010));
        @(posedge rclk);
        #1;
        req_vld = '0;
        chk("t1_memre", 32'(memre), 32'(1));
        chk("t1_memra", 32'(memra), 32'(10'h155));
        drive('0, 1'b1, 6);

        // Move ptr to 0, then everyone requests continuously.
        drive(4'b1000, 1'b1, 1);
        drive(4'b1111, 1'b1, 5);
        drive('0, 1'b1, 8);

        // Wrap fairness: grant 2 sets ptr to 3, then 3 must beat 0.
        drive(4'b0100, 1'b1, 1);
        req_vld = 4'b1001;
        #1 chk("wrap_rdy3", 32'(req_rdy), 32'(4'b1000));
        @(posedge rclk);
        #1 chk("wrap_rdy0", 32'(req_rdy), 32'(4'b0001));
        drive(4'b1001, 1'b1, 1);
        drive('0, 1'b1, 6);

        // clrrdy low blocks grants; an already issued read still responds.
        drive(4'b1111, 1'b0, 3);
        drive(4'b1111, 1'b1, 1);
        drive(4'b1111, 1'b0, 2);
        drive('0, 1'b1, 8);

        // Reset two cycles after a grant discards the read.
        drive(4'b0001, 1'b1, 1);
        drive('0, 1'b1, 1);
        rst_n = 1'b0;
        @(posedge rclk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_memre", 32'(memre), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        drive('0, 1'b1, 8);

        // Idle hold after one response.
        req_add  = N*AW'({$urandom(), $urandom()});
        hold_add = req_add[2*AW +: AW];
        drive(4'b0100, 1'b1, 1);
        drive('0, 1'b1, 12);
        chk("idle_memra", 32'(memra), 32'(hold_add));
        chk("idle_rsp_dat", 32'(rsp_dat), 32'(mdata(hold_add)));
        chk("idle_busy", 32'(busy), 32'(0));

        // Random traffic with occasional clrrdy drops.
        for (int i = 0; i < 60; i++) begin
            req_add = N*AW'({$urandom(), $urandom()});
            drive(N'($urandom()), ($urandom_range(0, 7) != 0), 1);
        end
        drive('0, 1'b1, 8);
        chk("drain", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rd_arb3x.md
# mem_rd_arb3x

Round-robin read-port arbiter and response router for a 3-cycle-latency simple-dual-port memory wrapper. It shares one memory read port among G_NREQ requesters and registers the selected address onto the port. It tracks every issued read through a tag pipeline matched to the memory latency, then returns the read data to the originating requester with a one-hot valid. It sits in the read clock domain (rclk) between requester logic and the memory read port.

## Interface
- G_NREQ, 4, number of requesters (2..16)
- G_RDADDR, 10, read address width
- G_RDWIDTH, 16, read data width
- G_LAT, 3, memory read latency in cycles from memre sampled to memdo valid
- rclk  in  1  read clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clrrdy  in  1  memory clear done; 0 blocks new grants
- req_vld  in  G_NREQ  per-requester read request
- req_add  in  G_NREQ*G_RDADDR  per-requester address, requester i at [i*G_RDADDR +: G_RDADDR]
- req_rdy  out  G_NREQ  one-hot grant (combinational); request accepted when req_vld[i]&req_rdy[i]
- memre  out  1  registered read enable to memory
- memra  out  G_RDADDR  registered read address to memory
- memdo  in  G_RDWIDTH  memory read data, valid G_LAT cycles after memre
- rsp_vld  out  G_NREQ  registered one-hot response valid
- rsp_dat  out  G_RDWIDTH  registered response data, shared by all requesters
- busy  out  1  registered; 1 while any read is in flight (memre or tag pipeline nonzero)

## Operation
- Grant: if clrrdy=1, pick the first i with req_vld[i]=1, searching from ptr upward modulo G_NREQ; req_rdy = one-hot(i). If there is no request or clrrdy=0, req_rdy = 0.
- ptr (log2 G_NREQ bits): after a grant to i, ptr <= (i+1) mod G_NREQ, wrapping G_NREQ-1 -> 0. It is unchanged when there is no grant.
- Issue: memre <= |req_rdy; memra <= req_add of the granted requester. When there is no grant, memra holds its previous value.
- Tag pipeline: G_LAT+1 stages of G_NREQ-bit one-hot. Stage 0 <= registered grant (aligned with memre), then shifts each cycle. The last stage aligns with valid memdo.
- Response: rsp_vld <= last tag stage; rsp_dat <= memdo when the last tag stage is nonzero, else hold.
- No response backpressure. Requesters must accept rsp_vld when it arrives.
- clrrdy falling mid-flight: new grants stop immediately. Reads already issued still complete and respond.
- Throughput: one grant per cycle, with no bubbles between back-to-back grants.
- Reset (rst_n=0 at a clock edge): ptr=0, memre=0, memra=0, all tag stages=0, rsp_vld=0, rsp_dat=0, busy=0. In-flight reads are discarded, and no rsp_vld may appear after reset from reads issued before it.

## Timing
- Cycle C: req_vld&req_rdy.
- C+1: memre=1, memra valid.
- C+1+G_LAT: memdo valid.
- C+2+G_LAT: rsp_vld/rsp_dat. With G_LAT=3, the response is at C+5.
- req_rdy depends combinationally on req_vld, clrrdy and ptr only. It has no dependency on memdo.
- busy=1 from C+1 through the cycle the response is registered (C+1+G_LAT).
- Up to G_LAT+1 reads are in flight. Responses return in grant order.

## Test plan
- Single request: reset, clrrdy=1; req_vld=4'b0010, req_add[1]=0x155 for 1 cycle at C -> req_rdy=4'b0010 at C; memre=1, memra=0x155 at C+1; rsp_vld=4'b0010, rsp_dat=mem[0x155] at C+5.
- All request continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; memre held at 1; rsp_vld 0001,0010,0100,1000,0001 at C+5..C+9, each carrying its own address's data.
- Wrap fairness: ptr=3 after grant to 2, req_vld=4'b1001 -> grant 3, then 0. Requester 0 must not be granted twice before requester 3.
- clrrdy=0 with req_vld=4'b1111 -> req_rdy=0, memre=0, ptr unchanged. Drop clrrdy to 0 one cycle after a grant -> that read's rsp_vld still appears at grant+5.
- Reset mid-flight: grant at C, rst_n=0 at C+2 for 1 cycle -> rsp_vld stays 0 through C+10; busy=0 and memre=0 in the first cycle after reset.
- Idle hold: after one response, req_vld=0 for 10 cycles -> rsp_dat holds the last value, rsp_vld=0, memra holds the last address, busy=0.
